// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready handshake on both sides.
// Single-cycle ops go through EXEC; MUL is iterative shift-add, one multiplier bit per cycle.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] NumA,
   input  logic [WIDTH-1:0] NumB,
   input  logic [2:0]       ALUOP,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Result,
   output logic [WIDTH-1:0] result_hi,
   output logic [3:0]       flags
);

   // state | meaning
   // IDLE  | in_ready=1, waiting for a request
   // EXEC  | single-cycle op computed from latched operands
   // MUL   | shift-add iteration, WIDTH cycles
   // HOLD  | out_valid=1, outputs frozen until out_ready
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] MUL  = 2'd2;
   localparam logic [1:0] HOLD = 2'd3;

   localparam int SW = $clog2(WIDTH);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] result_hi_q, result_hi_d;
   logic [3:0]       flags_q, flags_d;

   logic [WIDTH:0]   add_w;
   logic [WIDTH:0]   sub_w;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_lo;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;

   assign add_w = {1'b0, a_q} + {1'b0, b_q};
   assign sub_w = {1'b0, a_q} - {1'b0, b_q};

   // b_q doubles as the low half of the product: the multiplier shifts out as product bits shift in
   assign mul_sum = {1'b0, hi_q} + (b_q[0] ? {1'b0, a_q} : '0);
   assign mul_lo  = {mul_sum[0], b_q[WIDTH-1:1]};

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op_q)
         OP_ADD: begin
            alu_res = add_w[WIDTH-1:0];
            alu_c   = add_w[WIDTH];
            alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = sub_w[WIDTH-1:0];
            alu_c   = sub_w[WIDTH];
            alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_AND:  alu_res = a_q & b_q;
         OP_OR:   alu_res = a_q | b_q;
         OP_XOR:  alu_res = a_q ^ b_q;
         OP_SHL:  alu_res = a_q << b_q[SW-1:0];
         OP_SHR:  alu_res = a_q >> b_q[SW-1:0];
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      hi_d        = hi_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      flags_d     = flags_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = NumA;
               b_d     = NumB;
               op_d    = ALUOP;
               hi_d    = '0;
               cnt_d   = '0;
               state_d = (ALUOP == OP_MUL) ? MUL : EXEC;
            end
         end
         EXEC: begin
            result_d    = alu_res;
            result_hi_d = '0;
            flags_d     = {alu_c, alu_v, alu_res[WIDTH-1], (alu_res == '0)};
            state_d     = HOLD;
         end
         MUL: begin
            hi_d  = mul_sum[WIDTH:1];
            b_d   = mul_lo;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               result_d    = mul_lo;
               result_hi_d = mul_sum[WIDTH:1];
               flags_d     = {(mul_sum[WIDTH:1] != '0), 1'b0, mul_lo[WIDTH-1], (mul_lo == '0)};
               state_d     = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         hi_q        <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         result_hi_q <= '0;
         flags_q     <= '0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         hi_q        <= hi_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         flags_q     <= flags_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == HOLD);
   assign Result    = result_q;
   assign result_hi = result_hi_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq against an arithmetic reference model.
// Covers handshake latency, backpressure, ignored inputs and mid-operation reset.
module tb_alu_seq;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] NumA = '0;
   logic [W-1:0] NumB = '0;
   logic [2:0]   ALUOP = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] Result;
   logic [W-1:0] result_hi;
   logic [3:0]   flags;

   int n_checks = 0;
   int n_errors = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .NumA      (NumA),
      .NumB      (NumB),
      .ALUOP     (ALUOP),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Result    (Result),
      .result_hi (result_hi),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic with signed interpretation for overflow
   task automatic ref_op(input int op, input int a, input int b,
                         output int res, output int hi, output int fl);
      int mask;
      int sa;
      int sb;
      int s;
      int full;
      int c;
      int v;
      mask = (1 << W) - 1;
      sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
      sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
      c = 0;
      v = 0;
      hi = 0;
      res = 0;
      case (op)
         0: begin
            full = a + b;
            res = full & mask;
            c = (full > mask) ? 1 : 0;
            s = sa + sb;
            v = (s > (1 << (W - 1)) - 1 || s < -(1 << (W - 1))) ? 1 : 0;
         end
         1: begin
            res = (a - b) & mask;
            c = (a < b) ? 1 : 0;
            s = sa - sb;
            v = (s > (1 << (W - 1)) - 1 || s < -(1 << (W - 1))) ? 1 : 0;
         end
         2: res = a & b;
         3: res = a | b;
         4: res = a ^ b;
         5: res = (a << (b % W)) & mask;
         6: res = a >> (b % W);
         default: begin
            full = a * b;
            res = full & mask;
            hi = (full >> W) & mask;
            c = (hi != 0) ? 1 : 0;
         end
      endcase
      fl = (c << 3) | (v << 2) | (((res >> (W - 1)) & 1) << 1) | ((res == 0) ? 1 : 0);
   endtask

   // Issue one request, wait for the result, hold it for hold_cycles of backpressure, then drain
   task automatic do_op(input int op, input int a, input int b, input int hold_cycles);
      int exp_res;
      int exp_hi;
      int exp_fl;
      int k;
      int exp_lat;
      ref_op(op, a, b, exp_res, exp_hi, exp_fl);
      exp_lat = (op == 7) ? W : 1;
      chk("in_ready_idle", in_ready, 1);
      in_valid = 1'b1;
      NumA = W'(a);
      NumB = W'(b);
      ALUOP = 3'(op);
      @(posedge clk); #1;
      k = 0;
      while (!out_valid && k < 50) begin
         chk("in_ready_busy", in_ready, 0);
         in_valid = 1'b1;
         NumA = W'($urandom);
         NumB = W'($urandom);
         ALUOP = 3'($urandom);
         out_ready = 1'($urandom);
         @(posedge clk); #1;
         k++;
      end
      out_ready = 1'b0;
      chk("latency", k, exp_lat);
      chk("result", Result, exp_res);
      chk("result_hi", result_hi, exp_hi);
      chk("flags", flags, exp_fl);
      for (int i = 0; i < hold_cycles; i++) begin
         in_valid = 1'b1;
         NumA = W'($urandom);
         NumB = W'($urandom);
         ALUOP = 3'($urandom);
         @(posedge clk); #1;
         chk("hold_valid", out_valid, 1);
         chk("hold_ready", in_ready, 0);
         chk("hold_result", Result, exp_res);
         chk("hold_hi", result_hi, exp_hi);
         chk("hold_flags", flags, exp_fl);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("drain_valid", out_valid, 0);
      chk("drain_ready", in_ready, 1);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready", in_ready, 1);
      chk("rst_valid", out_valid, 0);
      chk("rst_result", Result, 0);
      chk("rst_hi", result_hi, 0);
      chk("rst_flags", flags, 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      do_op(0, 'hC8, 'h64, 0);
      do_op(1, 'h80, 'h01, 0);
      do_op(1, 'h05, 'h05, 0);
      do_op(7, 'hFF, 'hFF, 0);
      do_op(5, 'h01, 'h0B, 0);
      do_op(6, 'h80, 'h07, 0);
      do_op(0, 'h7F, 'h01, 5);
      do_op(7, 'h00, 'h5A, 2);

      // Reset during the third MUL cycle aborts with nothing delivered
      in_valid = 1'b1;
      NumA = 8'hFF;
      NumB = 8'hFF;
      ALUOP = 3'b111;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort_valid", out_valid, 0);
      chk("abort_result", Result, 0);
      chk("abort_hi", result_hi, 0);
      chk("abort_ready", in_ready, 1);
      @(posedge clk); #1;
      chk("abort_stay_idle", out_valid, 0);
      rst_n = 1'b1;
      do_op(0, 'h01, 'h01, 0);

      for (int n = 0; n < 150; n++) begin
         do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..32, power of two.
REQ-002 The module SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 The module SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The module SHALL have port in_valid  input  1  request present on NumA/NumB/ALUOP.
REQ-005 The module SHALL have port in_ready  output  1  module can accept a request.
REQ-006 The module SHALL have port NumA  input  WIDTH  operand A, unsigned/two's complement per op.
REQ-007 The module SHALL have port NumB  input  WIDTH  operand B.
REQ-008 The module SHALL have port ALUOP  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL (unsigned).
REQ-009 The module SHALL have port out_valid  output  1  Result and flags valid.
REQ-010 The module SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 The module SHALL have port Result  output  WIDTH  low WIDTH bits of the result.
REQ-012 The module SHALL have port result_hi  output  WIDTH  upper WIDTH bits of MUL product; 0 for other ops.
REQ-013 The module SHALL have port flags  output  4  {carry, overflow, negative, zero}, MSB to LSB.

Function
REQ-014 States SHALL be IDLE, EXEC, MUL, HOLD; in_ready SHALL be 1 exactly when state is IDLE.
REQ-015 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; NumA, NumB, ALUOP latched then; later input changes SHALL be ignored until the next accept.
REQ-016 IDLE -> EXEC on accept with ALUOP != 111; IDLE -> MUL on accept with ALUOP = 111; IDLE holds otherwise.
REQ-017 EXEC SHALL compute in one cycle and go to HOLD; out_valid SHALL be 1 on the first cycle after the EXEC cycle, i.e. 2 edges after accept.
REQ-018 MUL SHALL run unsigned shift-add, one multiplier bit per cycle, exactly WIDTH cycles, then go to HOLD; out_valid first 1 exactly WIDTH+1 edges after accept.
REQ-019 HOLD SHALL assert out_valid with Result, result_hi, flags stable; on an edge with out_ready=1 -> IDLE, out_valid falls same edge.
REQ-020 out_ready while out_valid=0 SHALL have no effect; in_valid outside IDLE SHALL be ignored (no queuing).
REQ-021 ADD: Result = (NumA+NumB) mod 2^WIDTH; carry = carry-out; overflow = signed overflow.
REQ-022 SUB: Result = (NumA-NumB) mod 2^WIDTH; carry = borrow (1 iff NumA < NumB unsigned); overflow = signed overflow.
REQ-023 AND/OR/XOR: bitwise; carry=0, overflow=0.
REQ-024 SHL/SHR: shift NumA by NumB[$clog2(WIDTH)-1:0], zero fill; upper NumB bits ignored; carry=0, overflow=0.
REQ-025 MUL: {result_hi, Result} = full 2*WIDTH-bit product; carry = 1 iff result_hi != 0; overflow=0.
REQ-026 For all ops: zero = (Result == 0); negative = Result[WIDTH-1]; result_hi = 0 for non-MUL ops.
REQ-027 Iteration counter SHALL be $clog2(WIDTH)+1 bits, cleared on accept, never wrap mid-operation.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state IDLE, out_valid=0, Result=0, result_hi=0, flags=0, counter and operand registers 0; in_ready=1 while in reset.
REQ-029 Reset asserted mid-EXEC, mid-MUL or in HOLD SHALL abort the operation with no result delivered; first accept possible on the first edge after rst_n rises.

Verification (WIDTH=8)
REQ-030 ADD NumA=0xC8, NumB=0x64 -> 2 edges after accept: Result=0x2C, result_hi=0x00, flags=1000 (carry only).
REQ-031 SUB NumA=0x80, NumB=0x01 -> Result=0x7F, flags=0100 (overflow only); SUB 0x05-0x05 -> Result=0x00, flags=0001.
REQ-032 MUL 0xFF*0xFF -> out_valid exactly 9 edges after accept, Result=0x01, result_hi=0xFE, flags=1000; in_ready=0 throughout.
REQ-033 SHL NumA=0x01, NumB=0x0B -> Result=0x08; SHR NumA=0x80, NumB=0x07 -> Result=0x01, flags=0000.
REQ-034 Backpressure: out_ready=0 for 5 cycles after out_valid, in_valid=1 with new operands -> outputs unchanged, in_ready=0, new request not accepted until after out_ready=1 edge.
REQ-035 Reset at 3rd MUL cycle -> out_valid=0, Result=0, in_ready=1 immediately; after release ADD 0x01+0x01 -> Result=0x02, flags=0000.
